key_event_module: RTL and testbench

//   Sits directly downstream of debounce_module and consumes its clean, active-low key level.

---
 rtl/key_event_module.sv | 137 +++++++++++++
 tb/tb_key_event_module.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_module.sv
// Key gesture classifier: turns a debounced active-low key level into single-cycle
// short / double / long / auto-repeat event pulses, timed by a ms prescaler.
module key_event_module #(
    parameter int MS_CNT    = 50000,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic CLK,
    input  logic RST,
    input  logic Key_In,
    output logic Short_Sig,
    output logic Double_Sig,
    output logic Long_Sig,
    output logic Repeat_Sig,
    output logic Key_Busy
);

    localparam int PW = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG_HOLD,
        WAIT_2ND,
        PRESS2,
        WAIT_REL
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            key_q_reg;
    logic [PW-1:0]   prescaler_reg;
    logic [15:0]     ms_cnt_reg;

    logic fall;
    logic rise;
    logic tick;
    logic long_hit;
    logic dclick_hit;
    logic repeat_hit;
    logic short_next;
    logic double_next;
    logic long_next;
    logic repeat_next;
    logic timer_clear;

    assign fall = key_q_reg & ~Key_In;
    assign rise = ~key_q_reg & Key_In;
    assign tick = (prescaler_reg == PW'(MS_CNT - 1));

    // A threshold is hit on the edge where ms_cnt steps from N-1 to N.
    assign long_hit   = tick && (ms_cnt_reg == 16'(LONG_MS - 1));
    assign dclick_hit = tick && (ms_cnt_reg == 16'(DCLICK_MS - 1));
    assign repeat_hit = tick && (ms_cnt_reg == 16'(REPEAT_MS - 1));

    always_comb begin
        state_next  = state_reg;
        short_next  = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall) state_next = PRESS1;
            end
            PRESS1: begin
                if (rise) begin
                    state_next = WAIT_2ND;
                end else if (long_hit) begin
                    long_next  = 1'b1;
                    state_next = LONG_HOLD;
                end
            end
            LONG_HOLD: begin
                if (rise) state_next = IDLE;
                else if (repeat_hit) repeat_next = 1'b1;
            end
            WAIT_2ND: begin
                if (fall) begin
                    state_next = PRESS2;
                end else if (dclick_hit) begin
                    short_next = 1'b1;
                    state_next = IDLE;
                end
            end
            PRESS2: begin
                // The second press is a double click whether released early or held long.
                if (rise) begin
                    double_next = 1'b1;
                    state_next  = IDLE;
                end else if (long_hit) begin
                    double_next = 1'b1;
                    state_next  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign timer_clear = (state_next != state_reg) || repeat_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            key_q_reg     <= 1'b1;
            prescaler_reg <= '0;
            ms_cnt_reg    <= '0;
            Short_Sig     <= 1'b0;
            Double_Sig    <= 1'b0;
            Long_Sig      <= 1'b0;
            Repeat_Sig    <= 1'b0;
            Key_Busy      <= 1'b0;
        end else begin
            key_q_reg  <= Key_In;
            state_reg  <= state_next;
            Short_Sig  <= short_next;
            Double_Sig <= double_next;
            Long_Sig   <= long_next;
            Repeat_Sig <= repeat_next;
            Key_Busy   <= (state_next != IDLE);
            if (timer_clear) begin
                prescaler_reg <= '0;
                ms_cnt_reg    <= '0;
            end else if (tick) begin
                prescaler_reg <= '0;
                if (ms_cnt_reg != 16'hFFFF) ms_cnt_reg <= ms_cnt_reg + 16'd1;
            end else begin
                prescaler_reg <= prescaler_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_event_module.sv
// Randomized scoreboard bench for key_event_module: a gesture-level model predicts
// pulse times and busy intervals from key segment durations; a monitor compares.
module tb_key_event_module;

    localparam int MS_CNT    = 10;
    localparam int LONG_MS   = 5;
    localparam int DCLICK_MS = 3;
    localparam int REPEAT_MS = 2;
    localparam int LC   = MS_CNT * LONG_MS;
    localparam int DC   = MS_CNT * DCLICK_MS;
    localparam int RC   = MS_CNT * REPEAT_MS;
    localparam int INF  = 1000000000;
    localparam int MAXC = 60000;

    localparam logic [3:0] EV_SHORT  = 4'b1000;
    localparam logic [3:0] EV_DOUBLE = 4'b0100;
    localparam logic [3:0] EV_LONG   = 4'b0010;
    localparam logic [3:0] EV_REPEAT = 4'b0001;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Key_In = 1'b1;
    logic Short_Sig, Double_Sig, Long_Sig, Repeat_Sig, Key_Busy;

    key_event_module #(
        .MS_CNT(MS_CNT), .LONG_MS(LONG_MS), .DCLICK_MS(DCLICK_MS), .REPEAT_MS(REPEAT_MS)
    ) dut (
        .CLK(CLK), .RST(RST), .Key_In(Key_In),
        .Short_Sig(Short_Sig), .Double_Sig(Double_Sig), .Long_Sig(Long_Sig),
        .Repeat_Sig(Repeat_Sig), .Key_Busy(Key_Busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [3:0] code;
    } ev_t;

    ev_t exp_q[$];
    bit  exp_busy [MAXC];
    bit  seg_lvl[$];
    int  seg_dur[$];
    int  errors = 0;
    int  checks = 0;
    bit  final_req = 1'b0;

    function automatic void push_ev(int t, logic [3:0] code, int cutoff);
        ev_t e;
        if (t < cutoff) begin
            e.t = t;
            e.code = code;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void mark_busy(int a, int b, int cutoff);
        for (int c = a; c < b && c < cutoff && c < MAXC; c++) exp_busy[c] = 1'b1;
    endfunction

    // Gesture rules applied to edge times: durations of press/gap decide the outcome.
    function automatic void model(int k0, int cutoff);
        int  tr[$];
        int  k = k0;
        bit  prev = 1'b1;
        int  i = 0;
        int  p, r, f, r2, fin;
        foreach (seg_lvl[j]) begin
            if (seg_lvl[j] != prev) tr.push_back(k + 1);
            prev = seg_lvl[j];
            k += seg_dur[j];
        end
        while (i < tr.size()) begin
            p = tr[i];
            r = (i + 1 < tr.size()) ? tr[i + 1] : INF;
            if (r - p <= LC) begin
                f = (i + 2 < tr.size()) ? tr[i + 2] : INF;
                if (f - r <= DC) begin
                    r2 = (i + 3 < tr.size()) ? tr[i + 3] : INF;
                    push_ev((r2 - f <= LC) ? r2 : f + LC, EV_DOUBLE, cutoff);
                    fin = r2;
                    i += 4;
                end else begin
                    push_ev(r + DC, EV_SHORT, cutoff);
                    fin = r + DC;
                    i += 2;
                end
            end else begin
                push_ev(p + LC, EV_LONG, cutoff);
                for (int t = p + LC + RC; t < r && t < cutoff && t < MAXC; t += RC)
                    push_ev(t, EV_REPEAT, cutoff);
                fin = r;
                i += 2;
            end
            mark_busy(p, fin, cutoff);
        end
    endfunction

    function automatic void seg(bit lvl, int dur);
        seg_lvl.push_back(lvl);
        seg_dur.push_back(dur);
    endfunction

    // Called at posedge+2; each segment value is first sampled on the following edge.
    task automatic run(input bit with_reset);
        int k0 = cyc;
        int total = 0;
        foreach (seg_dur[j]) total += seg_dur[j];
        model(k0, with_reset ? k0 + total : INF);
        $display("run at cycle %0d: %0d segments, %0d cycles, reset_at_end=%0d",
                 k0, seg_dur.size(), total, with_reset);
        foreach (seg_lvl[j]) begin
            Key_In = seg_lvl[j];
            repeat (seg_dur[j]) @(posedge CLK);
            #2;
        end
        if (with_reset) begin
            RST = 1'b1;
            repeat (2) @(posedge CLK);
            #2;
            Key_In = 1'b1;
            repeat (2) @(posedge CLK);
            #2;
            RST = 1'b0;
        end
        seg_lvl.delete();
        seg_dur.delete();
    endtask

    always @(negedge CLK) begin
        logic [3:0] act;
        ev_t        e;
        act = {Short_Sig, Double_Sig, Long_Sig, Repeat_Sig};
        if (cyc >= MAXC - 100) begin
            $display("FAIL watchdog: cycle %0d reached, required below %0d", cyc, MAXC - 100);
            $fatal(1, "watchdog expired");
        end
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: cycle %0d actual none, required code %b at cycle %0d",
                     cyc, e.code, e.t);
        end
        if (act != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d actual code %b, required none", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.code != act) begin
                    errors++;
                    $display("FAIL pulse: actual code %b at cycle %0d, required code %b at cycle %0d",
                             act, cyc, e.code, e.t);
                end else begin
                    $display("pulse code %b at cycle %0d as predicted", act, cyc);
                end
            end
        end
        checks++;
        if (Key_Busy !== exp_busy[cyc]) begin
            errors++;
            $display("FAIL busy: cycle %0d actual %b, required %b", cyc, Key_Busy, exp_busy[cyc]);
        end
        if (final_req) begin
            final_req = 1'b0;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pending_events: actual %0d outstanding, required 0", exp_q.size());
            end
        end
    end

    initial begin
        int n, sel;
        bit rst_end;
        RST = 1'b1;
        Key_In = 1'b1;
        repeat (5) @(posedge CLK);
        #2;
        RST = 1'b0;

        // Idle after reset
        seg(1, 200); run(0);
        // Short press
        seg(0, 20); seg(1, 60); run(0);
        // Double click
        seg(0, 20); seg(1, 10); seg(0, 20); seg(1, 60); run(0);
        // Long press with repeats
        seg(0, 120); seg(1, 60); run(0);
        // Release exactly at the long threshold
        seg(0, LC); seg(1, 60); run(0);
        // Second press exactly at the double-click timeout, then one cycle late
        seg(0, 20); seg(1, DC); seg(0, 20); seg(1, 60); run(0);
        seg(0, 20); seg(1, DC + 1); seg(0, 20); seg(1, 60); run(0);
        // Second press held past the long threshold
        seg(0, 20); seg(1, 10); seg(0, 90); seg(1, 60); run(0);
        // Reset during PRESS1, during LONG_HOLD, then a normal short press
        seg(0, 25); run(1);
        seg(1, 10); seg(0, 80); run(1);
        seg(1, 10); seg(0, 20); seg(1, 60); run(0);

        for (int g = 0; g < 30; g++) begin
            n = $urandom_range(1, 3);
            rst_end = ($urandom_range(0, 5) == 0);
            seg(1, $urandom_range(1, 10));
            for (int j = 0; j < n; j++) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: seg(0, LC);
                    1: seg(0, $urandom_range(1, LC - 1));
                    2: seg(0, $urandom_range(LC + 1, 110));
                    default: seg(0, $urandom_range(1, 30));
                endcase
                if (j < n - 1) begin
                    sel = $urandom_range(0, 2);
                    seg(1, (sel == 0) ? DC : (sel == 1) ? DC + 1 : $urandom_range(1, 45));
                end
            end
            if (!rst_end) seg(1, 50);
            run(rst_end);
        end

        repeat (5) @(posedge CLK);
        #2;
        final_req = 1'b1;
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
